// File: rtl/bsmac_pkg.sv
// bsmac_pkg: types and helpers shared by the bit-serial MAC sequencer.
//   state_e        : sequencer states
//   PREC_*         : prec_level encodings (3 aliases the 4-bit setting)
//   bits_for_prec  : bit cycles per element for a prec_level
//   ACC_W_DEF      : default MAC accumulator / result width
package bsmac_pkg;

    localparam int ACC_W_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] PREC_8  = 2'd0;
    localparam logic [1:0] PREC_4  = 2'd1;
    localparam logic [1:0] PREC_2  = 2'd2;
    localparam logic [1:0] PREC_4A = 2'd3;

    function automatic logic [3:0] bits_for_prec(input logic [1:0] prec);
        logic [3:0] b;
        case (prec)
            PREC_8:  b = 4'd8;
            PREC_2:  b = 4'd2;
            default: b = 4'd4;  // PREC_4 and its alias PREC_4A
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bsmac_bitcnt.sv
// bsmac_bitcnt: bit-cycle counter for one element of a bit-serial MAC.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart at 0 (a new operand pair was loaded); wins over en
//   en       : advance one bit cycle; wraps to 0 after the terminal count
//   bits     : bit cycles per element (B)
//   tc       : counter sits on the last bit cycle (B-1)
module bsmac_bitcnt
    import bsmac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] bits,
    output logic       tc
);

    logic [3:0] cnt_q, cnt_d;

    assign tc = (cnt_q == bits - 4'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bsmac_seq_ctrl.sv
// bsmac_seq_ctrl: job sequencer between an operand buffer and a bit-serial MAC.
// A job (len elements, prec_level) is accepted in IDLE; each activation/weight
// pair is pulled over op_valid/op_ready, held on mac_act/mac_wgt for B bit
// cycles with mac_en high, then one DRAIN cycle lets the MAC fold its last
// product before mac_result is captured and offered on res_valid/res_ready.
//   clk, rst                 : clock, synchronous active-high reset
//   start, len, prec_level   : job request (sampled only in IDLE)
//   busy                     : not IDLE
//   op_valid/op_ready, op_act, op_wgt : operand stream
//   mac_act, mac_wgt, mac_en, mac_clr, mac_prec, mac_result : MAC interface
//   res_valid/res_ready, res_data     : result port
//   stall_cnt (BSMAC_SEQ_CTRL_PERF_EN only) : LOAD cycles with op_valid low,
//                              cleared on job acceptance, saturating
module bsmac_seq_ctrl
    import bsmac_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       prec_level,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_act,
    input  logic [7:0]       op_wgt,
    output logic [7:0]       mac_act,
    output logic [7:0]       mac_wgt,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [1:0]       mac_prec,
    input  logic [ACC_W-1:0] mac_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
`ifdef BSMAC_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;     // elements not yet pulled
    logic [1:0]       prec_q, prec_d;
    logic [7:0]       act_q, act_d;
    logic [7:0]       wgt_q, wgt_d;
    logic [ACC_W-1:0] res_q, res_d;

    logic [3:0] bits;
    logic       tc;
    logic       accept;
    logic       load_pair;

    assign accept    = (state_q == ST_IDLE) && start;
    assign bits      = bits_for_prec(prec_q);
    // In RUN the next pair is requested on the last bit cycle so a ready
    // operand follows with no bubble.
    assign op_ready  = (state_q == ST_LOAD) ||
                       ((state_q == ST_RUN) && tc && (rem_q != '0));
    assign load_pair = op_valid && op_ready;

    bsmac_bitcnt u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_pair),
        .en   (state_q == ST_RUN),
        .bits (bits),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        prec_d  = prec_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    prec_d  = prec_level;
                    res_d   = '0;
                    state_d = (len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_pair)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tc) begin
                    if (rem_q == '0)
                        state_d = ST_DRAIN;
                    else if (!load_pair)
                        state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                res_d   = mac_result;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_pair) begin
            act_d = op_act;
            wgt_d = op_wgt;
            rem_d = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            prec_q  <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            prec_q  <= prec_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mac_en    = (state_q == ST_RUN);
    // Clear is held for the whole reset and pulsed in the accepting cycle,
    // so the MAC is empty before the first enabled bit cycle.
    assign mac_clr   = rst || accept;
    assign mac_act   = act_q;
    assign mac_wgt   = wgt_q;
    assign mac_prec  = prec_q;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_q;

`ifdef BSMAC_SEQ_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept)
            stall_d = '0;
        else if ((state_q == ST_LOAD) && !op_valid && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_bsmac_seq_ctrl.sv
// Self-checking bench for bsmac_seq_ctrl. A behavioural bit-serial MAC drives
// mac_result; each job's expected result, handshake timing, mac_en windows and
// stall count come from a job-level model (per-element ready/available times).
module tb_bsmac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, op_valid, res_ready;
    logic [7:0]  len, op_act, op_wgt, mac_act, mac_wgt;
    logic [1:0]  prec_level, mac_prec;
    logic        busy, op_ready, mac_en, mac_clr, res_valid;
    logic [19:0] mac_result, res_data;
`ifdef BSMAC_SEQ_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] act_a [256];
    logic [7:0] wgt_a [256];
    int         gap_a [256];

    always #5 clk = ~clk;

    bsmac_seq_ctrl dut (
`ifdef BSMAC_SEQ_CTRL_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prec_level (prec_level),
        .busy       (busy),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_act     (op_act),
        .op_wgt     (op_wgt),
        .mac_act    (mac_act),
        .mac_wgt    (mac_wgt),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_prec   (mac_prec),
        .mac_result (mac_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    function automatic int bits_of(input int p);
        return (p == 0) ? 8 : (p == 2) ? 2 : 4;
    endfunction

    // Bit-serial MAC: one weight bit per enabled cycle, LSB first, top bit negative.
    int macc = 0;
    int midx = 0;
    always @(posedge clk) begin
        int bb, v;
        bb = bits_of(int'(mac_prec));
        if (mac_clr) begin
            macc <= 0;
            midx <= 0;
        end else if (mac_en) begin
            v = mac_wgt[midx] ? (int'(mac_act) << midx) : 0;
            if (midx == bb - 1) v = -v;
            macc <= macc + v;
            midx <= (midx >= bb - 1) ? 0 : midx + 1;
        end
    end
    assign mac_result = macc[19:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            act_a[i] = 8'($urandom);
            wgt_a[i] = 8'($urandom);
            gap_a[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, maxgap)) : 0;
        end
    endtask

    // Runs one job; abort_at > 0 asserts rst in that job cycle instead of finishing.
    task automatic run_job(input int n, input int prec, input int hold, input int abort_at);
        int b, w, exp_res, k, last_hs, ready_t, load_t, avail_t, done_t, stall, t;
        bit any_hs, exp_ready, exp_en, in_load;
        logic [7:0] cur_act, cur_wgt;

        b = bits_of(prec);
        exp_res = 0;
        for (int i = 0; i < n; i++) begin
            w = int'(wgt_a[i]) & ((1 << b) - 1);
            if (w >= (1 << (b - 1))) w -= (1 << b);
            exp_res += int'(act_a[i]) * w;
        end
        exp_res = exp_res & 32'hFFFFF;

        // cycle 0: IDLE, request accepted
        chk("idle_busy", busy, 0);
        start = 1'b1; len = 8'(n); prec_level = 2'(prec); op_valid = 1'b0; res_ready = 1'b0;
        #1;
        chk("start_clr", mac_clr, 1);
        tick();
        start = 1'b0;
        k = 0; any_hs = 0; last_hs = 0; cur_act = '0; cur_wgt = '0; stall = 0;
        ready_t = 1; load_t = 1; avail_t = 1 + gap_a[0];
        done_t = (n == 0) ? 1 : 0;
        t = 1;
        while (t != done_t && t < 20000) begin
            if (t == abort_at) begin
                rst = 1'b1; start = 1'b0; op_valid = 1'b0;
                tick();
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_ready", op_ready, 0);
                chk("abort_en", mac_en, 0);
                chk("abort_clr", mac_clr, 1);
                chk("abort_valid", res_valid, 0);
                chk("abort_act", mac_act, 0);
                chk("abort_res", res_data, 0);
                rst = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    op_valid = 1'($urandom);
                    tick();
                    #1;
                    chk("post_abort_valid", res_valid, 0);
                    chk("post_abort_busy", busy, 0);
                end
                op_valid = 1'b0;
                return;
            end
            exp_ready = (k < n) && (t >= ready_t);
            in_load   = (k < n) && (t >= load_t);
            exp_en    = any_hs && (t > last_hs) && (t <= last_hs + b);
            op_valid  = (k < n) && (t >= avail_t);
            op_act    = op_valid ? act_a[k] : 8'($urandom);
            op_wgt    = op_valid ? wgt_a[k] : 8'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            len       = 8'($urandom);
            prec_level = 2'($urandom);
            res_ready = 1'($urandom);
            #1;
`ifdef BSMAC_SEQ_CTRL_PERF_EN
            if (t == 1) chk("stall_cleared", stall_cnt, 0);
`endif
            chk("run_busy", busy, 1);
            chk("op_ready", op_ready, exp_ready);
            chk("mac_en", mac_en, exp_en);
            chk("run_valid", res_valid, 0);
            chk("run_clr", mac_clr, 0);
            chk("mac_prec", mac_prec, prec);
            if (exp_en) begin
                chk("mac_act", mac_act, cur_act);
                chk("mac_wgt", mac_wgt, cur_wgt);
            end
            if (in_load && !op_valid) stall++;
            if (op_valid && exp_ready) begin
                cur_act = act_a[k]; cur_wgt = wgt_a[k];
                last_hs = t; any_hs = 1; k++;
                if (k < n) begin
                    ready_t = t + b;
                    load_t  = t + b + 1;
                    avail_t = t + 1 + gap_a[k];
                end else begin
                    done_t = t + b + 2;
                end
            end
            tick();
            t++;
        end
        if (t != done_t) begin
            chk("job_timeout", t, done_t);
            return;
        end

        // DONE: result held while res_ready low; start here is ignored
        start = 1'b0; res_ready = 1'b0; op_valid = 1'($urandom);
        #1;
        chk("done_valid", res_valid, 1);
        chk("done_res", res_data, exp_res);
        chk("done_ready", op_ready, 0);
        chk("done_en", mac_en, 0);
`ifdef BSMAC_SEQ_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, stall);
`endif
        for (int h = 0; h < hold; h++) begin
            start = (h % 3 == 1);
            len = 8'($urandom);
            tick();
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_res", res_data, exp_res);
            chk("hold_ready", op_ready, 0);
        end
        start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0; res_ready = 1'b0; op_valid = 1'b0;
        #1;
        chk("back_idle", busy, 0);
        chk("idle_valid", res_valid, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; len = '0; prec_level = '0;
        op_valid = 1'b0; op_act = '0; op_wgt = '0; res_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 0);
        chk("rst_en", mac_en, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_clr", mac_clr, 1);
        chk("rst_act", mac_act, 0);
        chk("rst_wgt", mac_wgt, 0);
        chk("rst_res", res_data, 0);
        chk("rst_prec", mac_prec, 0);
`ifdef BSMAC_SEQ_CTRL_PERF_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        rst = 1'b0;
        tick();
        #1;
        chk("post_rst_clr", mac_clr, 0);

        // len=3, 8-bit, no stalls: 5*4 + 3*(-1) + 2*7 = 31, res_valid in cycle 27
        act_a[0] = 8'd5; act_a[1] = 8'd3; act_a[2] = 8'd2;
        wgt_a[0] = 8'd4; wgt_a[1] = 8'hFF; wgt_a[2] = 8'd7;
        gap_a[0] = 0; gap_a[1] = 0; gap_a[2] = 0;
        run_job(3, 0, 0, 0);

        // len=4, 2-bit, operand gap before the third element
        fill(4, 1);
        gap_a[0] = 0; gap_a[1] = 0; gap_a[2] = 4; gap_a[3] = 0;
        run_job(4, 2, 1, 0);

        // empty job
        run_job(0, 1, 0, 0);

        // result held 10 cycles with start pulses, then released
        fill(2, 1);
        gap_a[0] = 0; gap_a[1] = 0;
        run_job(2, 0, 10, 0);

        // reset at bit 3 of element 1
        fill(5, 1);
        for (int i = 0; i < 5; i++) gap_a[i] = 0;
        run_job(5, 0, 0, 13);

        // stall accounting: 3 + 4 op_valid-low LOAD cycles
        fill(2, 1);
        gap_a[0] = 3; gap_a[1] = 6;
        run_job(2, 2, 0, 0);
        fill(1, 1);
        gap_a[0] = 0;
        run_job(1, 3, 0, 0);

        // longest job
        fill(255, 1);
        for (int i = 0; i < 255; i++) gap_a[i] = 0;
        run_job(255, 0, 0, 0);

        for (int j = 0; j < 15; j++) begin
            n = int'($urandom_range(1, 12));
            fill(n, 4);
            run_job(n, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
